// File: rtl/fetch_decode_queue.sv
// ---------------------------------------------------------------------------
// multicore_pkg / fetch_decode_queue
//
// Purpose: circular instruction queue between the fetch stage and the decode
// stage. Fetch pushes {instruction, pc, pc+4}; decode pops the head entry.
// A branch/jump flush empties the queue and discards the incoming
// instruction. o_stall is raised one slot early so that the fetch request
// already in flight still has room to land.
//
// Optional feature macro: FETCH_QUEUE_BYPASS_EN
//   defined   -> an instruction arriving at an empty queue is presented on the
//                head outputs in the same cycle; if decode accepts it in that
//                cycle it is never written into the queue.
//   undefined -> head outputs come only from storage (1-cycle latency, no
//                input-to-output combinational path).
//
// Ports:
//   i_aclk          clock
//   i_areset_n      asynchronous active-low reset
//   i_instruction   instruction from fetch
//   i_instr_valid   instruction/pc/pc+4 inputs are valid this cycle
//   i_pc            PC of i_instruction
//   i_pcplus4       i_pc + 4
//   i_flush         discard all queued and incoming instructions
//   i_decode_ready  decode consumes the head entry this cycle
//   o_instruction   head instruction
//   o_pc            head PC
//   o_pcplus4       head PC + 4
//   o_valid         head entry is valid
//   o_stall         tells fetch to stop issuing new requests
//   o_overflow      sticky: a valid instruction was dropped on a full queue
// ---------------------------------------------------------------------------
package multicore_pkg;
    localparam int INST_SIZE = 32;
endpackage

module fetch_decode_queue
    import multicore_pkg::*;
#(
    parameter int ADDR_SIZE = 32,
    parameter int DEPTH     = 4
) (
    input  logic                 i_aclk,
    input  logic                 i_areset_n,
    input  logic [INST_SIZE-1:0] i_instruction,
    input  logic                 i_instr_valid,
    input  logic [ADDR_SIZE-1:0] i_pc,
    input  logic [ADDR_SIZE-1:0] i_pcplus4,
    input  logic                 i_flush,
    input  logic                 i_decode_ready,
    output logic [INST_SIZE-1:0] o_instruction,
    output logic [ADDR_SIZE-1:0] o_pc,
    output logic [ADDR_SIZE-1:0] o_pcplus4,
    output logic                 o_valid,
    output logic                 o_stall,
    output logic                 o_overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_STALL = CNT_W'(DEPTH - 1);

    // Storage is data only: never reset, written only on push.
    logic [INST_SIZE-1:0] inst_mem   [0:DEPTH-1];
    logic [ADDR_SIZE-1:0] pc_mem     [0:DEPTH-1];
    logic [ADDR_SIZE-1:0] pcplus4_mem[0:DEPTH-1];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic not_empty;
    logic full;
    logic pop;
    logic push;
    logic drop;
    logic bypass;

    assign not_empty = (count != '0);
    assign full      = (count == CNT_FULL);

`ifdef FETCH_QUEUE_BYPASS_EN
    // Gated by reset so o_valid stays low while the queue is held in reset.
    assign bypass = i_areset_n & ~not_empty & i_instr_valid & ~i_flush;
`else
    assign bypass = 1'b0;
`endif

    assign o_valid = (not_empty | bypass) & ~i_flush;

    // A bypassed instruction is not in storage, so accepting it is not a pop.
    assign pop = o_valid & i_decode_ready & not_empty;

    // A bypassed instruction that decode takes right away never gets stored.
    assign push = i_instr_valid & ~i_flush & (~full | pop) & ~(bypass & i_decode_ready);

    assign drop = i_instr_valid & ~i_flush & full & ~pop;

    assign o_stall = (count >= CNT_STALL);

    always_comb begin
        o_instruction = inst_mem[rd_ptr];
        o_pc          = pc_mem[rd_ptr];
        o_pcplus4     = pcplus4_mem[rd_ptr];
        if (bypass) begin
            o_instruction = i_instruction;
            o_pc          = i_pc;
            o_pcplus4     = i_pcplus4;
        end
    end

    always_ff @(posedge i_aclk) begin
        if (push) begin
            inst_mem[wr_ptr]    <= i_instruction;
            pc_mem[wr_ptr]      <= i_pc;
            pcplus4_mem[wr_ptr] <= i_pcplus4;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky until reset; a flush does not clear it.
    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            o_overflow <= 1'b0;
        end else if (drop) begin
            o_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_decode_queue.sv
module tb_fetch_decode_queue;

    localparam int ADDR_SIZE = 32;
    localparam int DEPTH     = 4;

    logic                 clk;
    logic                 areset_n;
    logic [31:0]          instruction;
    logic                 instr_valid;
    logic [ADDR_SIZE-1:0] pc;
    logic [ADDR_SIZE-1:0] pcplus4;
    logic                 flush;
    logic                 decode_ready;
    logic [31:0]          out_instruction;
    logic [ADDR_SIZE-1:0] out_pc;
    logic [ADDR_SIZE-1:0] out_pcplus4;
    logic                 out_valid;
    logic                 out_stall;
    logic                 out_overflow;

    int n_checks = 0;
    int n_fails  = 0;

    fetch_decode_queue #(
        .ADDR_SIZE(ADDR_SIZE),
        .DEPTH    (DEPTH)
    ) dut (
        .i_aclk        (clk),
        .i_areset_n    (areset_n),
        .i_instruction (instruction),
        .i_instr_valid (instr_valid),
        .i_pc          (pc),
        .i_pcplus4     (pcplus4),
        .i_flush       (flush),
        .i_decode_ready(decode_ready),
        .o_instruction (out_instruction),
        .o_pc          (out_pc),
        .o_pcplus4     (out_pcplus4),
        .o_valid       (out_valid),
        .o_stall       (out_stall),
        .o_overflow    (out_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] p, input logic rdy, input logic fl);
        instr_valid  = v;
        pc           = p;
        pcplus4      = p + 32'd4;
        instruction  = 32'hC0DE_0000 ^ p;
        decode_ready = rdy;
        flush        = fl;
    endtask

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1-2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [31:0] p);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_pc"}, 64'(out_pc), 64'(p));
        check({tag, "_pcplus4"}, 64'(out_pcplus4), 64'(p + 32'd4));
        check({tag, "_inst"}, 64'(out_instruction), 64'(32'hC0DE_0000 ^ p));
    endtask

    initial begin
        areset_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        check("rst_count", 64'(dut.count), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_stall", 64'(out_stall), 64'd0);
        check("rst_overflow", 64'(out_overflow), 64'd0);
        tick();
        areset_n = 1'b1;
        tick();

        // In-order delivery of three queued instructions.
        drive(1'b1, 32'h100, 1'b0, 1'b0);
        tick();
        check_head("lat1", 32'h100);
        drive(1'b1, 32'h104, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h108, 1'b0, 1'b0);
        tick();
        check("three_stall", 64'(out_stall), 64'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        check_head("seq0", 32'h100);
        tick();
        check_head("seq1", 32'h104);
        tick();
        check_head("seq2", 32'h108);
        tick();
        check("seq_empty", 64'(out_valid), 64'd0);
        check("seq_count", 64'(dut.count), 64'd0);
        check("seq_stall", 64'(out_stall), 64'd0);

        // Fill, overflow, push+pop on full, wrap-around.
        drive(1'b1, 32'h500, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h504, 1'b0, 1'b0);
        tick();
        check("two_stall", 64'(out_stall), 64'd0);
        drive(1'b1, 32'h508, 1'b0, 1'b0);
        tick();
        check("fill3_stall", 64'(out_stall), 64'd1);
        check("fill3_count", 64'(dut.count), 64'd3);
        drive(1'b1, 32'h50C, 1'b0, 1'b0);
        tick();
        check("fill4_count", 64'(dut.count), 64'd4);
        check("fill4_ovf", 64'(out_overflow), 64'd0);
        drive(1'b1, 32'h510, 1'b0, 1'b0);
        tick();
        check("drop_count", 64'(dut.count), 64'd4);
        check("drop_ovf", 64'(out_overflow), 64'd1);
        check_head("drop_head", 32'h500);
        drive(1'b1, 32'h514, 1'b1, 1'b0);
        tick();
        check("pushpop_count", 64'(dut.count), 64'd4);
        check_head("pushpop_head", 32'h504);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        tick();
        check_head("wrap1", 32'h508);
        tick();
        check_head("wrap2", 32'h50C);
        tick();
        check_head("wrap3", 32'h514);
        tick();
        check("wrap_empty", 64'(out_valid), 64'd0);
        check("wrap_ovf", 64'(out_overflow), 64'd1);

        // Flush with two queued entries and a same-cycle push.
        drive(1'b1, 32'h600, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h604, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h200, 1'b1, 1'b1);
        #1;
        check("flush_valid_now", 64'(out_valid), 64'd0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        #1;
        check("flush_valid_next", 64'(out_valid), 64'd0);
        check("flush_count", 64'(dut.count), 64'd0);
        check("flush_ovf_kept", 64'(out_overflow), 64'd1);
        tick();
        check("flush_no_200", 64'(out_valid), 64'd0);

        // Reset mid-operation with three entries queued.
        drive(1'b1, 32'h700, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h704, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h708, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        check("pre_rst_count", 64'(dut.count), 64'd3);
        areset_n = 1'b0;
        #1;
        check("mid_rst_count", 64'(dut.count), 64'd0);
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_stall", 64'(out_stall), 64'd0);
        check("mid_rst_ovf", 64'(out_overflow), 64'd0);
        #1;
        areset_n = 1'b1;
        tick();
        drive(1'b1, 32'h300, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        check_head("post_rst", 32'h300);
        check("post_rst_rdptr", 64'(dut.rd_ptr), 64'd0);
        check("post_rst_wrptr", 64'(dut.wr_ptr), 64'd1);
        check("post_rst_ovf", 64'(out_overflow), 64'd0);

`ifdef FETCH_QUEUE_BYPASS_EN
        // Drain, then bypass an instruction straight to decode.
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'h400, 1'b1, 1'b0);
        #1;
        check_head("bypass", 32'h400);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        check("bypass_count", 64'(dut.count), 64'd0);
        check("bypass_after", 64'(out_valid), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/fetch_decode_queue.md
FETCH_DECODE_QUEUE -- requirements
Module: fetch_decode_queue

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 32: width of the PC fields.
REQ-002 SHALL have parameter DEPTH, default 4: entries; power of two, >= 2.
REQ-003 SHALL take INST_SIZE (32) from multicore_pkg.
REQ-004 i_aclk  in  1  system clock; the only clock.
REQ-005 i_areset_n  in  1  asynchronous, active-low reset.
REQ-006 i_instruction  in  INST_SIZE  instruction from fetch.
REQ-007 i_instr_valid  in  1  i_instruction, i_pc and i_pcplus4 are valid this cycle.
REQ-008 i_pc  in  ADDR_SIZE  PC of i_instruction.
REQ-009 i_pcplus4  in  ADDR_SIZE  i_pc + 4.
REQ-010 i_flush  in  1  branch/jump taken: discard all queued and incoming instructions.
REQ-011 i_decode_ready  in  1  decode consumes the head entry this cycle.
REQ-012 o_instruction, o_pc, o_pcplus4  out  INST_SIZE/ADDR_SIZE/ADDR_SIZE  head entry fields.
REQ-013 o_valid  out  1  head entry is valid.
REQ-014 o_stall  out  1  to the fetch i_stall input: stop issuing new requests.
REQ-015 o_overflow  out  1  sticky flag: a valid instruction was dropped because the queue was full.

Function
REQ-016 SHALL be a circular FIFO with wr_ptr, rd_ptr and a count of width log2(DEPTH)+1; both pointers SHALL wrap modulo DEPTH.
REQ-017 push SHALL equal i_instr_valid & ~i_flush & (count < DEPTH | pop).
REQ-018 pop SHALL equal o_valid & i_decode_ready.
REQ-019 A push SHALL write {i_instruction, i_pc, i_pcplus4} at wr_ptr and increment wr_ptr.
REQ-020 A pop SHALL increment rd_ptr.
REQ-021 count SHALL be +1 on push only, -1 on pop only, and unchanged on push+pop, including when count = DEPTH.
REQ-022 Head fields SHALL be driven combinationally from the entry at rd_ptr.
REQ-023 o_valid SHALL equal (count != 0) & ~i_flush.
REQ-024 o_stall SHALL equal count >= DEPTH-1, leaving one slot for the fetch request already in flight.
REQ-025 On i_flush, at the next edge count, wr_ptr and rd_ptr SHALL be 0; a same-cycle i_instr_valid is discarded, and a same-cycle i_decode_ready has no effect.
REQ-026 i_instr_valid with count = DEPTH and no pop SHALL drop the instruction and set o_overflow at the next edge; o_overflow SHALL clear only on reset and SHALL be unaffected by i_flush.
REQ-027 Without bypass, the push-to-o_valid latency SHALL be 1 cycle.
REQ-028 Empty queue with no push SHALL hold o_valid = 0; head fields are don't-care.

Reset
REQ-029 While i_areset_n = 0, the following SHALL be 0 asynchronously: count, wr_ptr, rd_ptr, o_overflow, o_valid and o_stall.
REQ-030 Storage array contents SHALL not be reset.
REQ-031 Reset asserted mid-operation SHALL discard all entries; the first push after deassertion SHALL be held at entry 0.

Configuration
REQ-032 Macro FETCH_QUEUE_BYPASS_EN defined: when count = 0 and i_instr_valid & ~i_flush, o_valid SHALL be 1 in the same cycle and the head fields SHALL be the input fields.
REQ-033 With FETCH_QUEUE_BYPASS_EN defined and i_decode_ready = 1 in that cycle, the instruction SHALL not be stored; otherwise it is pushed normally.
REQ-034 Macro FETCH_QUEUE_BYPASS_EN undefined: no input-to-output combinational path SHALL exist, and REQ-027 holds.

Verification
REQ-035 Push pc 0x100, 0x104, 0x108 with i_decode_ready = 0, then hold i_decode_ready = 1 -> o_pc 0x100, 0x104, 0x108 on consecutive cycles; o_valid drops after the third.
REQ-036 DEPTH = 4: push 3 -> o_stall = 1; push a 4th -> count 4; push a 5th with no pop -> dropped, o_overflow = 1 persists.
REQ-037 Full queue: push and pop in the same cycle -> count stays 4; the new entry is output after 3 further pops, proving wrap-around.
REQ-038 2 entries queued, i_flush with i_instr_valid (pc 0x200) -> o_valid = 0 in that cycle and the next; count 0; 0x200 is never output.
REQ-039 Assert reset with 3 entries, release, push pc 0x300 -> o_pc = 0x300 one cycle later (or same cycle with FETCH_QUEUE_BYPASS_EN); o_overflow = 0.
REQ-040 With FETCH_QUEUE_BYPASS_EN: empty queue, i_instr_valid pc 0x400 with i_decode_ready = 1 -> o_valid = 1, o_pc = 0x400 same cycle; count stays 0.
